// File: rtl/vend_pkg.sv
// Shared types and constants for the parametrised coin vending controller.
// States are one-hot so each output decodes from a single state bit.
package vend_pkg;

   typedef enum logic [3:0] {
      ST_COLLECT = 4'b0001,
      ST_VEND    = 4'b0010,
      ST_CHANGE  = 4'b0100,
      ST_REFUND  = 4'b1000
   } state_t;

   localparam int COIN_HALF_VAL = 1;
   localparam int COIN_ONE_VAL  = 2;

endpackage

// File: rtl/vend_change_dispenser.sv
// Serial change/refund payout: a down-counter of half-units that pays a
// one-unit coin while two or more remain, otherwise a half-unit coin.
module vend_change_dispenser #(
   parameter int CREDIT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [CREDIT_W-1:0] load_val,
   output logic                change_one,
   output logic                change_half,
   output logic                done
);

   logic [CREDIT_W-1:0] rem;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem <= '0;
      end else if (load) begin
         rem <= load_val;
      end else if (rem >= CREDIT_W'(2)) begin
         rem <= rem - CREDIT_W'(2);
      end else begin
         rem <= '0;
      end
   end

   // done flags the cycle whose decrement empties the counter
   assign change_one  = (rem >= CREDIT_W'(2));
   assign change_half = (rem == CREDIT_W'(1));
   assign done        = change_half | (rem == CREDIT_W'(2));

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates half/one-unit coins toward
// PRICE, holds the dispense request until acknowledged, then pays change.
module vend_fsm_param
   import vend_pkg::*;
#(
   parameter int PRICE    = 5,
   parameter int CREDIT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          in,
   input  logic                cancel,
   input  logic                vend_ack,
   output logic                out,
   output logic                change_half,
   output logic                change_one,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   if (PRICE < 1 || PRICE + 2 > (2 ** CREDIT_W) - 1) begin : g_param_check
      $error("vend_fsm_param: PRICE must be 1..2**CREDIT_W-3");
   end

   state_t              state, state_nx;
   logic [CREDIT_W-1:0] credit_q, credit_nx;
   logic [CREDIT_W-1:0] pend_rem, pend_rem_nx;
   logic [CREDIT_W-1:0] add, sum;
   logic                disp_load;
   logic [CREDIT_W-1:0] disp_val;
   logic                disp_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_COLLECT;
         credit_q <= '0;
         pend_rem <= '0;
      end else begin
         state    <= state_nx;
         credit_q <= credit_nx;
         pend_rem <= pend_rem_nx;
      end
   end

   // Both coin strobes together count as both coins
   assign add = (in[0] ? CREDIT_W'(COIN_HALF_VAL) : '0)
              + (in[1] ? CREDIT_W'(COIN_ONE_VAL)  : '0);
   assign sum = credit_q + add;

   always_comb begin
      state_nx    = state;
      credit_nx   = credit_q;
      pend_rem_nx = pend_rem;
      disp_load   = 1'b0;
      disp_val    = '0;
      case (state)
         ST_COLLECT: begin
            if (cancel && sum != '0) begin
               disp_load = 1'b1;
               disp_val  = sum;
               credit_nx = '0;
               state_nx  = ST_REFUND;
            end else if (sum >= CREDIT_W'(PRICE)) begin
               pend_rem_nx = sum - CREDIT_W'(PRICE);
               credit_nx   = '0;
               state_nx    = ST_VEND;
            end else begin
               credit_nx = sum;
            end
         end
         // Change is held here and handed to the dispenser only on ack
         ST_VEND: begin
            if (vend_ack) begin
               pend_rem_nx = '0;
               if (pend_rem != '0) begin
                  disp_load = 1'b1;
                  disp_val  = pend_rem;
                  state_nx  = ST_CHANGE;
               end else begin
                  state_nx = ST_COLLECT;
               end
            end
         end
         ST_CHANGE, ST_REFUND: begin
            if (disp_done) state_nx = ST_COLLECT;
         end
         default: begin
            state_nx    = ST_COLLECT;
            credit_nx   = '0;
            pend_rem_nx = '0;
         end
      endcase
   end

   vend_change_dispenser #(.CREDIT_W(CREDIT_W)) u_disp (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (disp_load),
      .load_val    (disp_val),
      .change_one  (change_one),
      .change_half (change_half),
      .done        (disp_done)
   );

   assign out    = (state == ST_VEND);
   assign busy   = (state != ST_COLLECT);
   assign credit = credit_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed vector bench for vend_fsm_param (PRICE=5) plus a random
// coin-balance scoreboard on a PRICE=13 instance.
module tb_vend_fsm_param;

   logic       clk = 1'b0;
   logic       rst_n, cancel, vend_ack;
   logic [1:0] coin_in;
   logic       out, change_half, change_one, busy;
   logic [3:0] credit;

   logic       b_rst_n, b_cancel, b_ack;
   logic [1:0] b_in;
   logic       b_out, b_half, b_one, b_busy;
   logic [3:0] b_credit;

   int vec_count  = 0;
   int miss_count = 0;

   typedef struct {
      logic       rst_n;
      logic [1:0] coins;
      logic       cancel;
      logic       ack;
      logic       e_out;
      logic       e_half;
      logic       e_one;
      logic [3:0] e_credit;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   vend_fsm_param #(.PRICE(5), .CREDIT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in(coin_in), .cancel(cancel),
      .vend_ack(vend_ack), .out(out), .change_half(change_half),
      .change_one(change_one), .credit(credit), .busy(busy)
   );

   vend_fsm_param #(.PRICE(13), .CREDIT_W(4)) dut13 (
      .clk(clk), .rst_n(b_rst_n), .in(b_in), .cancel(b_cancel),
      .vend_ack(b_ack), .out(b_out), .change_half(b_half),
      .change_one(b_one), .credit(b_credit), .busy(b_busy)
   );

   task automatic add_vec(input logic r, input logic [1:0] c, input logic cn,
                          input logic a, input logic eo, input logic eh,
                          input logic e1, input logic [3:0] ec, input logic eb);
      vecs.push_back('{r, c, cn, a, eo, eh, e1, ec, eb});
   endtask

   task automatic check_val(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s #%0d: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   // Drive one vector, clock it, and compare {out,half,one,credit,busy}
   task automatic applyStimulus(input vec_t v, input string name, input int idx);
      rst_n    = v.rst_n;
      coin_in  = v.coins;
      cancel   = v.cancel;
      vend_ack = v.ack;
      @(posedge clk);
      #1;
      check_val(name, idx, {24'd0, out, change_half, change_one, credit, busy},
                {24'd0, v.e_out, v.e_half, v.e_one, v.e_credit, v.e_busy});
   endtask

   task automatic step(input logic r, input logic [1:0] c, input logic cn,
                       input logic a, input logic eo, input logic eh,
                       input logic e1, input logic [3:0] ec, input logic eb,
                       input string name, input int idx);
      vec_t v;
      v = '{r, c, cn, a, eo, eh, e1, ec, eb};
      applyStimulus(v, name, idx);
   endtask

   initial begin
      int coins_in, vends, paid_out, both_hi, guard;
      rst_n = 1'b0; coin_in = 2'b00; cancel = 1'b0; vend_ack = 1'b0;
      b_rst_n = 1'b0; b_in = 2'b00; b_cancel = 1'b0; b_ack = 1'b0;

      //      rst in     cncl ack  out half one credit busy
      add_vec(0, 2'b11, 0, 0,   0, 0, 0, 4'd0, 0);   // reset, coins ignored
      add_vec(0, 2'b11, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b01, 0, 0,   0, 0, 0, 4'd1, 0);   // exact price
      add_vec(1, 2'b01, 0, 0,   0, 0, 0, 4'd2, 0);
      add_vec(1, 2'b01, 0, 0,   0, 0, 0, 4'd3, 0);
      add_vec(1, 2'b01, 0, 0,   0, 0, 0, 4'd4, 0);
      add_vec(1, 2'b01, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 1,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd2, 0);   // change of 2
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd4, 0);
      add_vec(1, 2'b11, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 1,   0, 0, 1, 4'd0, 1);
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd2, 0);   // change of 1
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd4, 0);
      add_vec(1, 2'b10, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 1,   0, 1, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd2, 0);   // refund of 3
      add_vec(1, 2'b01, 0, 0,   0, 0, 0, 4'd3, 0);
      add_vec(1, 2'b00, 1, 0,   0, 0, 1, 4'd0, 1);
      add_vec(1, 2'b10, 0, 0,   0, 1, 0, 4'd0, 1);
      add_vec(1, 2'b10, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b00, 1, 0,   0, 0, 0, 4'd0, 0);   // cancel with no credit
      add_vec(1, 2'b01, 1, 0,   0, 1, 0, 4'd0, 1);   // coin with cancel refunded
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b11, 0, 0,   0, 0, 0, 4'd3, 0);   // cancel ignored in VEND
      add_vec(1, 2'b10, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 1, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b10, 0, 0,   1, 0, 0, 4'd0, 1);
      add_vec(1, 2'b00, 0, 1,   0, 0, 0, 4'd0, 0);
      add_vec(1, 2'b00, 0, 0,   0, 0, 0, 4'd0, 0);

      @(negedge clk);
      foreach (vecs[i]) applyStimulus(vecs[i], "table", i);

      // Long hold of the dispense request without ack
      step(1, 2'b10, 0, 0, 0, 0, 0, 4'd2, 0, "hold", 0);
      step(1, 2'b10, 0, 0, 0, 0, 0, 4'd4, 0, "hold", 1);
      step(1, 2'b01, 0, 0, 1, 0, 0, 4'd0, 1, "hold", 2);
      for (int i = 0; i < 10; i++) step(1, 2'b00, 0, 0, 1, 0, 0, 4'd0, 1, "hold_wait", i);
      step(1, 2'b00, 0, 1, 0, 0, 0, 4'd0, 0, "hold_ack", 0);

      // Reset while vending with change pending drops the change
      step(1, 2'b10, 0, 0, 0, 0, 0, 4'd2, 0, "rst_vend", 0);
      step(1, 2'b10, 0, 0, 0, 0, 0, 4'd4, 0, "rst_vend", 1);
      step(1, 2'b11, 0, 0, 1, 0, 0, 4'd0, 1, "rst_vend", 2);
      step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0, 0, "rst_vend", 3);
      for (int i = 0; i < 5; i++) step(1, 2'b00, 0, 1, 0, 0, 0, 4'd0, 0, "rst_after", i);

      // Random stream on PRICE=13: coins in must equal items + change + credit
      b_rst_n = 1'b1;
      @(posedge clk); #1;
      coins_in = 0; vends = 0; paid_out = 0; both_hi = 0;
      for (int i = 0; i < 600; i++) begin
         if (b_half && b_one) both_hi++;
         paid_out += (b_one ? 2 : 0) + (b_half ? 1 : 0);
         b_in     = 2'($urandom_range(0, 3));
         b_cancel = ($urandom_range(0, 15) == 0);
         b_ack    = ($urandom_range(0, 3) == 0);
         if (!b_busy) coins_in += int'(b_in[0]) + 2 * int'(b_in[1]);
         if (b_out && b_ack) vends++;
         @(posedge clk); #1;
      end
      b_in = 2'b00; b_cancel = 1'b0; b_ack = 1'b1;
      guard = 0;
      while (b_busy && guard < 100) begin
         if (b_half && b_one) both_hi++;
         paid_out += (b_one ? 2 : 0) + (b_half ? 1 : 0);
         if (b_out) vends++;
         @(posedge clk); #1;
         guard++;
      end
      check_val("drain_timeout", 0, {31'd0, b_busy}, 32'd0);
      check_val("both_change", 0, both_hi, 0);
      check_val("balance", 0, coins_in, vends * 13 + paid_out + int'(b_credit));
      check_val("vends_seen", 0, {31'd0, vends > 0}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised successor to the team's 2.5-unit coin vending FSM.
- Accepts half-unit and one-unit coins and accumulates credit toward a configurable PRICE.
- Holds a dispense request until it is acknowledged, then pays change serially; a cancel refunds the accumulated credit.
- Sits between the coin-acceptor front end and the dispenser/payout mechanics.

Parameters:
- PRICE, 5, item price in half-units (5 = 2.5); legal range 1..(2^CREDIT_W - 3).
- CREDIT_W, 4, width of the credit and change counters; must satisfy PRICE+2 <= 2^CREDIT_W - 1 (elaboration check).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in  in  2  coin strobes, one cycle per coin: in[0] = half-unit (value 1), in[1] = one-unit (value 2).
- cancel  in  1  refund request, one-cycle pulse.
- vend_ack  in  1  dispenser acknowledge of out.
- out  out  1  dispense request (level).
- change_half  out  1  pay one half-unit coin this cycle.
- change_one  out  1  pay one one-unit coin this cycle.
- credit  out  CREDIT_W  current accumulated credit (half-units).
- busy  out  1  high outside COLLECT; coin front end must reject coins while high.

Behaviour:
- Reset is one clock, synchronous and active-low: clk, rst_n as named. rst_n low at an edge forces:
  - state = COLLECT;
  - credit = 0, change remainder = 0;
  - so out = change_half = change_one = busy = 0 from that edge.
  - Reset mid-VEND/CHANGE/REFUND discards the pending item and change; no partial payout continues.
- States (one-hot): COLLECT, VEND, CHANGE, REFUND. Outputs are decoded from registered state/counters only; there is no combinational input-to-output path.
- COLLECT, per edge:
  - add = in[0]*1 + in[1]*2. in = 2'b11 counts both coins (add = 3); there is no priority drop.
  - sum = credit + add.
  - If cancel=1 and sum > 0: rem <= sum, credit <= 0, go to REFUND. A coin arriving in the same cycle as cancel is refunded.
  - If cancel=1 and sum = 0: cancel is ignored.
  - Else if sum >= PRICE: rem <= sum - PRICE, credit <= 0, go to VEND.
  - Else credit <= sum.
- VEND:
  - out = 1, busy = 1.
  - Stays in VEND while vend_ack = 0; there is no timeout.
  - On vend_ack = 1: go to CHANGE if rem > 0, else go to COLLECT.
  - cancel is ignored, because the item is already committed.
- CHANGE / REFUND (identical payout, different entry reason), each cycle:
  - If rem >= 2: change_one = 1, rem <= rem - 2.
  - If rem = 1: change_half = 1, rem <= rem - 1.
  - change_one and change_half are never both 1.
  - When the decrement makes rem = 0, go to COLLECT at that edge. Payout of r half-units therefore takes ceil(r/2) consecutive cycles.
- Coins and cancel present while busy = 1 are ignored and not counted.
- Latency:
  - A coin reaching PRICE sampled at edge k gives out = 1 from edge k onward.
  - vend_ack at edge j gives the first change token in cycle j..j+1 and out = 0 from edge j.
- credit reads the live credit register; it is 0 in VEND/CHANGE/REFUND.
- Arithmetic is unsigned CREDIT_W bits. The parameter check guarantees no overflow, since max sum = PRICE-1+3.

Decomposition:
- Package vend_pkg:
  - one-hot state localparams ST_COLLECT, ST_VEND, ST_CHANGE, ST_REFUND;
  - COIN_HALF_VAL = 1, COIN_ONE_VAL = 2.
- Sub-module vend_change_dispenser(clk, rst_n, load, load_val, change_one, change_half, done):
  - down-counter shared by CHANGE and REFUND;
  - top FSM loads it on entry and returns to COLLECT on done.

Test Plan:
- Reset: rst_n = 0 for 2 edges with in = 2'b11 -> all outputs 0, credit = 0; coins during reset are not counted.
- Exact price: five in = 2'b01 pulses -> credit 1,2,3,4; out = 1 after 5th edge; hold vend_ack = 0 for 10 cycles -> out stays 1; ack -> out = 0, no change pulses, busy = 0 next cycle.
- Change: in = 2'b10, 2'b10, 2'b11 -> credit 2, 4, then VEND with rem = 2; ack -> exactly one cycle change_one = 1, then COLLECT.
- Odd change: PRICE = 5, three in = 2'b10 -> sum 6, rem = 1; ack -> one cycle change_half = 1.
- Refund: in = 2'b10, in = 2'b01, cancel -> REFUND rem = 3: change_one cycle, then change_half cycle, then COLLECT with credit 0; in = 2'b10 during refund is ignored (credit still 0 afterwards).
- Reset mid-vend: reach VEND with rem = 2, vend_ack = 0, pulse rst_n = 0 one edge -> out = 0, busy = 0, no change pulses ever emitted.
- Parameter sweep: PRICE = 13, CREDIT_W = 4 -> random coin/cancel streams; scoreboard checks coins in = item value + change out.
